// File: rtl/sprite_compositor_sched.sv
// sprite_compositor_sched
//   Per-pixel ROM address scheduler and priority compositor for the Pac-Man
//   sprite bank (8 Pac-Man frames, ghosts r/p/b/o, cherry) and the board.
//
//   Optional feature macro: SPRITE_COLLIDE_EN adds the sticky collide[3:0]
//   output (Pac-Man vs ghost i overlap of two opaque pixels).
//
//   Ports:
//     Clk, Reset            clock, synchronous active-high reset
//     frame_start           one-cycle pulse at start of vertical blank
//     pixel_valid, DrawX/Y  scan position qualifier and coordinates
//     pac_*/ghost_*/cherry_* sprite positions, enables, Pac-Man direction
//     *_read_address        ROM addresses (ghosts packed 4x19, idx 0 = r)
//     pac_frame_sel         {dir, closed}, selects one of 8 Pac-Man ROMs
//     *_rgb (inputs)        ROM colours, ROM_LAT cycles after the address
//     pixel_rgb, rgb_valid  composited pixel, 2+ROM_LAT edges after sampling
//
//   Stream semantics: valid-only, no backpressure. pixel_valid qualifies
//   DrawX/DrawY on the edge that samples them; rgb_valid qualifies pixel_rgb
//   on the cycle it is high, and pixel_rgb is 0 whenever rgb_valid is 0.
module sprite_compositor_sched #(
  parameter int BG_W        = 280,
  parameter int BG_H        = 310,
  parameter int BG_X0       = 180,
  parameter int BG_Y0       = 85,
  parameter int ANIM_FRAMES = 8,
  parameter int ROM_LAT     = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_start,
  input  logic         pixel_valid,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic [9:0]   pac_x,
  input  logic [9:0]   pac_y,
  input  logic [1:0]   pac_dir,
  input  logic         pac_moving,
  input  logic [39:0]  ghost_x,
  input  logic [39:0]  ghost_y,
  input  logic [3:0]   ghost_en,
  input  logic [9:0]   cherry_x,
  input  logic [9:0]   cherry_y,
  input  logic         cherry_en,
  output logic [18:0]  pac_read_address,
  output logic [18:0]  cherry_read_address,
  output logic [75:0]  ghost_read_address,
  output logic [18:0]  bg_read_address,
  output logic [2:0]   pac_frame_sel,
  input  logic [23:0]  pac_rgb,
  input  logic [23:0]  cherry_rgb,
  input  logic [23:0]  bg_rgb,
  input  logic [95:0]  ghost_rgb,
`ifdef SPRITE_COLLIDE_EN
  output logic [3:0]   collide,
`endif
  output logic [23:0]  pixel_rgb,
  output logic         rgb_valid
);

  // Sprite slots: 0 = Pac-Man, 1..4 = ghosts 0..3, 5 = cherry (priority order).
  localparam int NS = 6;
  localparam logic [9:0]  X_LO      = 10'(BG_X0);
  localparam logic [9:0]  X_HI      = 10'(BG_X0 + BG_W);
  localparam logic [9:0]  Y_LO      = 10'(BG_Y0);
  localparam logic [9:0]  Y_HI      = 10'(BG_Y0 + BG_H);
  localparam logic [18:0] BG_W19    = 19'(BG_W);
  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_FRAMES - 1);

  // ---------------- Shadow registers (captured on frame_start) ------------
  logic [9:0]    sx_q [NS];
  logic [9:0]    sy_q [NS];
  logic [NS-1:1] sen_q;
  logic [NS-1:0] spr_en;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NS; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
      end
      sen_q <= '0;
    end else if (frame_start) begin
      sx_q[0] <= pac_x;
      sy_q[0] <= pac_y;
      for (int g = 0; g < 4; g++) begin
        sx_q[g+1] <= ghost_x[10*g +: 10];
        sy_q[g+1] <= ghost_y[10*g +: 10];
      end
      sx_q[5] <= cherry_x;
      sy_q[5] <= cherry_y;
      sen_q   <= {cherry_en, ghost_en};
    end
  end

  // Pac-Man has no enable; it is always drawn.
  assign spr_en = {sen_q, 1'b1};

  // ---------------- Mouth animation ---------------------------------------
  // pac_dir and pac_moving are only ever consumed at the capture edge, so the
  // animation state and pac_frame_sel register act as their shadow copies:
  // the moving value captured by a frame_start already governs that update.
  logic [7:0] cnt_q, cnt_d;
  logic       closed_q, closed_d;
  logic [2:0] sel_q, sel_d;

  always_comb begin
    cnt_d    = cnt_q;
    closed_d = closed_q;
    sel_d    = sel_q;
    if (frame_start) begin
      if (pac_moving) begin
        if (cnt_q == ANIM_LAST) begin
          cnt_d    = '0;
          closed_d = ~closed_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        cnt_d    = '0;
        closed_d = 1'b0;
      end
      sel_d = {pac_dir, closed_d};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      closed_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      closed_q <= closed_d;
      sel_q    <= sel_d;
    end
  end

  // ---------------- Stage A: hit test and address issue -------------------
  logic [9:0]    dx [NS];
  logic [9:0]    dy [NS];
  logic [NS-1:0] hit_d;
  logic [18:0]   addr_d [NS];
  logic [9:0]    rel_x, rel_y;
  logic          bin_d;
  logic [18:0]   bg_addr_d;

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NS; i++) begin
      // Wrapping 10-bit subtraction: positions left/above the sprite wrap to
      // large values and fail the <16 test without a separate sign check.
      dx[i]     = DrawX - sx_q[i];
      dy[i]     = DrawY - sy_q[i];
      hit_d[i]  = pixel_valid & spr_en[i] & (dx[i] < 10'd16) & (dy[i] < 10'd16);
      addr_d[i] = hit_d[i] ? {11'b0, dy[i][3:0], dx[i][3:0]} : '0;
    end
    rel_x     = DrawX - X_LO;
    rel_y     = DrawY - Y_LO;
    bin_d     = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
    bg_addr_d = bin_d ? (({9'b0, rel_y} * BG_W19) + {9'b0, rel_x}) : '0;
  end

  logic [18:0]   addr_q [NS];
  logic [18:0]   bg_addr_q;
  logic [NS-1:0] hit_q;
  logic          bin_q, vld_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NS; i++) addr_q[i] <= '0;
      bg_addr_q <= '0;
      hit_q     <= '0;
      bin_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) addr_q[i] <= addr_d[i];
      bg_addr_q <= bg_addr_d;
      hit_q     <= hit_d;
      bin_q     <= bin_d;
      vld_q     <= pixel_valid;
    end
  end

  // ---------------- Delay line matching the ROM read latency --------------
  logic [NS-1:0]      hit_dl_q [ROM_LAT];
  logic [ROM_LAT-1:0] bin_dl_q, vld_dl_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < ROM_LAT; k++) hit_dl_q[k] <= '0;
      bin_dl_q <= '0;
      vld_dl_q <= '0;
    end else begin
      hit_dl_q[0] <= hit_q;
      bin_dl_q[0] <= bin_q;
      vld_dl_q[0] <= vld_q;
      for (int k = 1; k < ROM_LAT; k++) begin
        hit_dl_q[k] <= hit_dl_q[k-1];
        bin_dl_q[k] <= bin_dl_q[k-1];
        vld_dl_q[k] <= vld_dl_q[k-1];
      end
    end
  end

  // ---------------- Stage C: priority / transparency composite ------------
  logic [23:0]   col [NS];
  logic [NS-1:0] hit_c, opq;
  logic [23:0]   pix_d;

  always_comb begin
    col[0] = pac_rgb;
    for (int g = 0; g < 4; g++) col[g+1] = ghost_rgb[24*g +: 24];
    col[5] = cherry_rgb;
    hit_c  = hit_dl_q[ROM_LAT-1];
    pix_d  = bin_dl_q[ROM_LAT-1] ? bg_rgb : 24'h000000;
    opq    = '0;
    // Walk from lowest to highest priority so the last opaque write wins.
    for (int i = NS - 1; i >= 0; i--) begin
      opq[i] = hit_c[i] & (col[i] != 24'h000000);
      if (opq[i]) pix_d = col[i];
    end
    if (!vld_dl_q[ROM_LAT-1]) pix_d = 24'h000000;
  end

  logic [23:0] pix_q;
  logic        rgbv_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_q  <= '0;
      rgbv_q <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      rgbv_q <= vld_dl_q[ROM_LAT-1];
    end
  end

`ifdef SPRITE_COLLIDE_EN
  logic [3:0] coll_q, coll_d;

  // frame_start clears the sticky bits; a collision composited on that same
  // edge still lands in the new frame's bits.
  always_comb begin
    coll_d = (frame_start ? 4'b0000 : coll_q) | ({4{opq[0]}} & opq[4:1]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) coll_q <= '0;
    else       coll_q <= coll_d;
  end

  assign collide = coll_q;
`endif

  // ---------------- Outputs ----------------------------------------------
  assign pac_read_address    = addr_q[0];
  assign ghost_read_address  = {addr_q[4], addr_q[3], addr_q[2], addr_q[1]};
  assign cherry_read_address = addr_q[5];
  assign bg_read_address     = bg_addr_q;
  assign pac_frame_sel       = sel_q;
  assign pixel_rgb           = pix_q;
  assign rgb_valid           = rgbv_q;

endmodule

// File: doc/sprite_compositor_sched.md
Name: sprite_compositor_sched

Overview:
- Per-pixel scheduler and compositor for the sprite/board ROM bank: Pac-Man (8 direction/mouth frames), four ghosts (r, p, b, o), cherry, and the 280x310 board background.
- From the VGA scan position, issues a read address to every ROM each pixel and picks the Pac-Man frame (direction plus mouth animation).
- Aligns returned colours to the fixed ROM latency, then composites them by priority and transparency into one RGB pixel for the VGA output stage.

Parameters:
- BG_W, 280, board width in pixels (board ROM depth = BG_W*BG_H = 86800).
- BG_H, 310, board height in pixels.
- BG_X0, 180, screen X of board left edge.
- BG_Y0, 85, screen Y of board top edge.
- ANIM_FRAMES, 8, video frames per mouth open/closed toggle; must be 1..255.
- ROM_LAT, 2, clock cycles from read address to valid colour on any ROM.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pixel_valid  in  1  DrawX/DrawY is in the active area this cycle.
- DrawX  in  10  current scan X.
- DrawY  in  10  current scan Y.
- pac_x, pac_y  in  10 each  Pac-Man top-left.
- pac_dir  in  2  direction: 00=R, 01=L, 10=U, 11=D.
- pac_moving  in  1  Pac-Man is moving.
- ghost_x, ghost_y  in  40 each  packed 4x10; index 0=r, 1=p, 2=b, 3=o.
- ghost_en  in  4  ghost visible.
- cherry_x, cherry_y  in  10 each; cherry_en  in  1.
- pac_read_address, cherry_read_address  out  19 each  sprite ROM addresses.
- ghost_read_address  out  76  packed 4x19.
- bg_read_address  out  19  board ROM address.
- pac_frame_sel  out  3  {pac_dir, closed}; selects 1 of 8 Pac-Man ROMs.
- pac_rgb, cherry_rgb, bg_rgb  in  24 each  ROM colours.
- ghost_rgb  in  96  packed 4x24 ROM colours.
- pixel_rgb  out  24  composited pixel.
- rgb_valid  out  1  pixel_rgb is valid.

Behaviour:
- Shadow registers:
  - All position, enable, pac_dir and pac_moving inputs are captured only on the cycle frame_start=1.
  - All pipeline logic uses these shadow copies, so no tearing occurs mid-frame.
  - Reset value of every shadow register is 0.
- Stage A (address issue; registered at the edge that samples DrawX/DrawY):
  - Per sprite: dx = DrawX - x and dy = DrawY - y, as 10-bit unsigned subtraction.
  - Hit when dx<16, dy<16, pixel_valid=1 and the sprite is enabled; Pac-Man is always enabled.
  - Sprite address = {11'b0, dy[3:0], dx[3:0]} on a hit, otherwise 0.
  - Board is "in" when BG_X0 <= DrawX < BG_X0+BG_W and BG_Y0 <= DrawY < BG_Y0+BG_H.
  - bg_read_address = (DrawY-BG_Y0)*BG_W + (DrawX-BG_X0) when in the board, otherwise 0.
  - Hit flags, the board-in flag and pixel_valid are registered together with the addresses.
- Delay line: hit flags, board-in flag and valid are delayed ROM_LAT further cycles so they align with the returned colours.
- Stage C (composite, registered): the colour value 24'h000000 is transparent. Priority, first opaque hit wins:
  1. Pac-Man.
  2. Ghost 0, 1, 2, 3 in that order.
  3. Cherry.
  4. bg_rgb if board-in, else 24'h000000.
- Latency: pixel_rgb and rgb_valid appear exactly 2+ROM_LAT edges after DrawX/DrawY are sampled (4 with defaults). rgb_valid=0 gives pixel_rgb=0.
- Animation:
  - 8-bit frame counter and a `closed` bit; both update only on frame_start.
  - If shadow pac_moving=1: counter increments. When it reaches ANIM_FRAMES-1 it wraps to 0 and closed toggles.
  - If pac_moving=0: counter=0 and closed=0 (mouth open).
  - pac_frame_sel is registered: {shadow pac_dir, closed}.
- Simultaneous events: frame_start together with pixel_valid=1 is an illegal input. If it occurs, the new shadow values apply from the next cycle; the current pixel uses the old values.
- Reset: all outputs, pipeline registers, counters and shadows go to 0 on the next edge, including mid-frame; in-flight pixels are discarded. Reset has priority over frame_start.
- Widths: bg address arithmetic is 19-bit unsigned; products never exceed 86799.

Optional Feature:
- Macro SPRITE_COLLIDE_EN.
- Defined:
  - Adds output collide [3:0].
  - In Stage C, bit i sets when the Pac-Man and ghost i colours are both opaque hits on the same pixel.
  - Bits are sticky until the next frame_start, which clears them; they clear on Reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles with pixel_valid=1 -> pixel_rgb=0, rgb_valid=0, pac_frame_sel=0, all addresses 0 until valid pixels re-enter the pipe.
- Shadow pac=(100,100), DrawX=103, DrawY=105 -> pac_read_address=0x053 after 1 edge. With pac_rgb=FFFB01 driven at the ROM latency, pixel_rgb=FFFB01 with rgb_valid=1 exactly 4 edges after sampling.
- Board pixel DrawX=180, DrawY=86 -> bg_read_address=280. Pixel (179,86) -> bg address 0 and pixel_rgb=000000 with no sprite hit.
- Pac-Man and ghost 0 overlap, both opaque -> pac_rgb. pac_rgb=0, ghost1 FF2500 and ghost3 FFB751 both opaque -> FF2500. All sprites transparent -> bg_rgb.
- ANIM_FRAMES=4, pac_dir=01, pac_moving=1 -> pac_frame_sel goes 010->011 after 4 frame_starts and back to 010 after 8. Dropping pac_moving forces 010 at the next frame_start.
- Change pac_x mid-frame -> addresses keep using the old x until after the next frame_start pulse. With SPRITE_COLLIDE_EN, overlap with ghost 2 sets collide=0100, which clears at frame_start.
